// File: rtl/arty_reset_sequencer.sv
// Reset sequencer for the i_clk_mhz domain: holds all stage resets, waits for a filtered
// MMCM lock, then releases stages in index order; re-sequences on lock loss or soft request.
module arty_reset_sequencer #(
   parameter int unsigned P_NUM_STAGES  = 3,
   parameter int unsigned P_HOLD_CYCLES = 16,
   parameter int unsigned P_LOCK_FILTER = 4,
   parameter int unsigned P_STAGE_GAP   = 8,
   parameter int unsigned P_SYNC_STAGES = 2
) (
   input  logic                    i_clk_mhz,
   input  logic                    i_rstn_global,
   input  logic                    i_mmcm_locked,
   input  logic                    i_soft_rst,
   output logic [P_NUM_STAGES-1:0] o_rst_stage,
   output logic                    o_ready,
   output logic [1:0]              o_rst_cause
);

   localparam int unsigned HoldW = (P_HOLD_CYCLES > 1) ? $clog2(P_HOLD_CYCLES) : 1;
   localparam int unsigned LockW = $clog2(P_LOCK_FILTER + 1);
   localparam int unsigned GapW  = (P_STAGE_GAP > 1) ? $clog2(P_STAGE_GAP) : 1;
   localparam int unsigned IdxW  = (P_NUM_STAGES > 1) ? $clog2(P_NUM_STAGES) : 1;

   localparam logic [HoldW-1:0] HoldLast = HoldW'(P_HOLD_CYCLES - 1);
   localparam logic [LockW-1:0] LockLast = LockW'(P_LOCK_FILTER - 1);
   localparam logic [GapW-1:0]  GapLast  = GapW'(P_STAGE_GAP - 1);
   localparam logic [IdxW-1:0]  IdxLast  = IdxW'(P_NUM_STAGES - 1);

   typedef enum logic [1:0] {StHold, StWaitLock, StRelease, StRun} state_e;

   state_e                  state_q, state_d;
   logic [P_SYNC_STAGES-1:0] sync_q;
   logic [HoldW-1:0]        hold_cnt_q, hold_cnt_d;
   logic [LockW-1:0]        lock_cnt_q, lock_cnt_d;
   logic [GapW-1:0]         gap_cnt_q, gap_cnt_d;
   logic [IdxW-1:0]         idx_q, idx_d;
   logic [P_NUM_STAGES-1:0] stage_q, stage_d;
   logic                    ready_q, ready_d;
   logic [1:0]              cause_q, cause_d;

   logic lock_s;
   logic lock_loss;
   logic soft_req;
   logic reseq;

   assign lock_s    = sync_q[P_SYNC_STAGES-1];
   // Lock loss outranks a coincident soft request, which only matters for the cause code.
   assign lock_loss = !lock_s && ((state_q == StRelease) || (state_q == StRun));
   assign soft_req  = i_soft_rst && (state_q == StRun);
   assign reseq     = lock_loss || soft_req;

   always_ff @(posedge i_clk_mhz or negedge i_rstn_global) begin
      if (!i_rstn_global) begin
         state_q    <= StHold;
         sync_q     <= '0;
         hold_cnt_q <= '0;
         lock_cnt_q <= '0;
         gap_cnt_q  <= '0;
         idx_q      <= '0;
         stage_q    <= '1;
         ready_q    <= 1'b0;
         cause_q    <= 2'b00;
      end else begin
         state_q    <= state_d;
         sync_q     <= {sync_q[P_SYNC_STAGES-2:0], i_mmcm_locked};
         hold_cnt_q <= hold_cnt_d;
         lock_cnt_q <= lock_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         idx_q      <= idx_d;
         stage_q    <= stage_d;
         ready_q    <= ready_d;
         cause_q    <= cause_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (reseq) begin
         state_d = StHold;
      end else begin
         case (state_q)
            StHold:     if (hold_cnt_q == HoldLast) state_d = StWaitLock;
            StWaitLock: if (lock_s && (lock_cnt_q == LockLast)) state_d = StRelease;
            StRelease:  if ((gap_cnt_q == GapLast) && (idx_q == IdxLast)) state_d = StRun;
            StRun:      state_d = StRun;
            default:    state_d = StHold;
         endcase
      end
   end

   always_comb begin
      hold_cnt_d = '0;
      lock_cnt_d = '0;
      gap_cnt_d  = '0;
      idx_d      = idx_q;
      stage_d    = stage_q;
      ready_d    = ready_q;
      cause_d    = cause_q;
      if (reseq) begin
         stage_d = '1;
         ready_d = 1'b0;
         idx_d   = '0;
         cause_d = lock_loss ? 2'b01 : 2'b10;
      end else begin
         case (state_q)
            StHold: begin
               if (hold_cnt_q != HoldLast) hold_cnt_d = hold_cnt_q + HoldW'(1);
            end
            StWaitLock: begin
               idx_d = '0;
               if (lock_s && (lock_cnt_q != LockLast)) lock_cnt_d = lock_cnt_q + LockW'(1);
            end
            StRelease: begin
               if (gap_cnt_q == GapLast) begin
                  for (int k = 0; k < int'(P_NUM_STAGES); k++) begin
                     if (idx_q == IdxW'(k)) stage_d[k] = 1'b0;
                  end
                  if (idx_q == IdxLast) ready_d = 1'b1;
                  else                  idx_d   = idx_q + IdxW'(1);
               end else begin
                  gap_cnt_d = gap_cnt_q + GapW'(1);
               end
            end
            StRun: begin
               stage_d = '0;
               ready_d = 1'b1;
            end
            default: begin
               stage_d = '1;
               ready_d = 1'b0;
            end
         endcase
      end
   end

   assign o_rst_stage = stage_q;
   assign o_ready     = ready_q;
   assign o_rst_cause = cause_q;

endmodule

// File: tb/tb_arty_reset_sequencer.sv
// Randomized bench for arty_reset_sequencer against an edge-arithmetic reference model.
module tb_arty_reset_sequencer;

   localparam int N    = 3;
   localparam int HOLD = 16;
   localparam int FILT = 4;
   localparam int GAP  = 8;
   localparam int SYNC = 2;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         lock_drv = 1'b0;
   logic         soft_drv = 1'b0;
   logic [N-1:0] rst_stage;
   logic         ready;
   logic [1:0]   cause;

   always #5 clk = ~clk;

   arty_reset_sequencer #(
      .P_NUM_STAGES (N),
      .P_HOLD_CYCLES(HOLD),
      .P_LOCK_FILTER(FILT),
      .P_STAGE_GAP  (GAP),
      .P_SYNC_STAGES(SYNC)
   ) dut (
      .i_clk_mhz    (clk),
      .i_rstn_global(rstn),
      .i_mmcm_locked(lock_drv),
      .i_soft_rst   (soft_drv),
      .o_rst_stage  (rst_stage),
      .o_ready      (ready),
      .o_rst_cause  (cause)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model: edges counted since reset release; lock_ok is the edge the filter was satisfied.
   int       m_edge;
   int       m_start;
   int       m_lock_ok;
   int       m_streak;
   logic [1:0] m_cause;
   bit       m_hist [0:8191];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int released(input int e);
      int r;
      if (m_lock_ok < 0) return 0;
      r = (e - m_lock_ok) / GAP;
      return (r > N) ? N : r;
   endfunction

   function automatic bit ls_before(input int e);
      return (e - SYNC >= 1) ? m_hist[(e - SYNC) % 8192] : 1'b0;
   endfunction

   function automatic logic [N-1:0] exp_stage();
      logic [N-1:0] s;
      int rel;
      rel = released(m_edge);
      for (int k = 0; k < N; k++) s[k] = (k >= rel);
      return s;
   endfunction

   function automatic logic exp_ready();
      return (m_lock_ok >= 0) && (released(m_edge) == N);
   endfunction

   task automatic model_reset();
      m_edge    = 0;
      m_start   = 0;
      m_lock_ok = -1;
      m_streak  = 0;
      m_cause   = 2'b00;
   endtask

   task automatic model_edge();
      bit ls;
      int rel_prev;
      m_edge++;
      ls = ls_before(m_edge);
      m_hist[m_edge % 8192] = lock_drv;
      rel_prev = released(m_edge - 1);
      if (m_lock_ok >= 0 && !ls) begin
         m_cause = 2'b01;
         m_start = m_edge; m_lock_ok = -1; m_streak = 0;
      end else if (m_lock_ok >= 0 && rel_prev == N && soft_drv) begin
         m_cause = 2'b10;
         m_start = m_edge; m_lock_ok = -1; m_streak = 0;
      end else if (m_lock_ok < 0 && m_edge > m_start + HOLD) begin
         m_streak = ls ? m_streak + 1 : 0;
         if (m_streak == FILT) m_lock_ok = m_edge;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_val($sformatf("stage@%0d", m_edge), rst_stage, exp_stage());
      check_val($sformatf("ready@%0d", m_edge), ready, exp_ready());
      check_val($sformatf("cause@%0d", m_edge), cause, m_cause);
   endtask

   task automatic do_reset(input logic lock_v);
      @(negedge clk);
      #2;
      rstn     = 1'b0;
      lock_drv = lock_v;
      soft_drv = 1'b0;
      #1;
      check_val("rst_stage", rst_stage, {N{1'b1}});
      check_val("rst_ready", ready, 1'b0);
      check_val("rst_cause", cause, 2'b00);
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic soft_pulse();
      soft_drv = 1'b1;
      cycle();
      soft_drv = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      int i;
      for (i = 0; i < 200 && !exp_ready(); i++) cycle();
      if (i >= 200) check_val({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_mid_release(input string tag);
      int i;
      for (i = 0; i < 200 && !(released(m_edge) >= 1 && released(m_edge) < N); i++) cycle();
      if (i >= 200) check_val({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      model_reset();

      // Power-on with lock high throughout.
      do_reset(1'b1);
      for (int i = 0; i < 50; i++) begin
         cycle();
         if (m_edge == 27) check_val("po_s0_pre", rst_stage, 3'b111);
         if (m_edge == 28) check_val("po_s0_rel", rst_stage, 3'b110);
         if (m_edge == 36) check_val("po_s1_rel", rst_stage, 3'b100);
         if (m_edge == 43) check_val("po_rdy_pre", ready, 1'b0);
         if (m_edge == 44) check_val("po_s2_rel", rst_stage, 3'b000);
         if (m_edge == 44) check_val("po_rdy", ready, 1'b1);
      end

      // Soft request in RUN.
      soft_pulse();
      check_val("soft_stage", rst_stage, 3'b111);
      check_val("soft_cause", cause, 2'b10);
      wait_ready("soft_reseq");

      // Soft request during RELEASE is ignored.
      soft_pulse();
      wait_mid_release("rel");
      soft_pulse();
      check_val("relsoft_cause", cause, 2'b10);
      check_val("relsoft_s0", rst_stage[0], 1'b0);
      wait_ready("relsoft");

      // Lock loss in RUN, then recovery.
      lock_drv = 1'b0;
      for (int i = 0; i < 3; i++) cycle();
      check_val("ll_stage", rst_stage, 3'b111);
      check_val("ll_cause", cause, 2'b01);
      for (int i = 0; i < 5; i++) cycle();
      lock_drv = 1'b1;
      wait_ready("ll_reseq");

      // Simultaneous lock loss and soft request in RUN.
      lock_drv = 1'b0;
      for (int i = 0; i < 5; i++) begin
         soft_drv = (ls_before(m_edge + 1) == 1'b0);
         cycle();
      end
      soft_drv = 1'b0;
      check_val("sim_cause", cause, 2'b01);
      lock_drv = 1'b1;
      wait_ready("sim_reseq");

      // Async reset mid-RELEASE.
      soft_pulse();
      wait_mid_release("arst");
      do_reset(1'b1);

      // Lock glitch during WAIT_LOCK restarts the filter.
      for (int i = 0; i < 40; i++) begin
         cycle();
         lock_drv = (m_edge == 17) ? 1'b0 : 1'b1;
         if (m_edge == 31) check_val("gl_s0_pre", rst_stage[0], 1'b1);
         if (m_edge == 32) check_val("gl_s0_rel", rst_stage[0], 1'b0);
      end

      // Lock low until edge 30.
      do_reset(1'b0);
      for (int i = 0; i < 50; i++) begin
         cycle();
         if (m_edge == 30) lock_drv = 1'b1;
         if (m_edge == 43) check_val("lk30_pre", rst_stage[0], 1'b1);
         if (m_edge == 44) check_val("lk30_rel", rst_stage[0], 1'b0);
         if (m_edge == 44) check_val("lk30_cause", cause, 2'b00);
      end

      // Randomized traffic.
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 999) == 0) do_reset(1'(($urandom_range(0, 3) != 0)));
         if (lock_drv) lock_drv = ($urandom_range(0, 99) >= 2);
         else          lock_drv = ($urandom_range(0, 99) < 30);
         soft_drv = ($urandom_range(0, 99) < 3);
         cycle();
      end
      soft_drv = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
